// File: rtl/booth_mult_pipe.sv
// rtl/booth_mult_pipe.sv - pipelined radix-4 Booth multiplier with carry-save reduction
//
// Purpose: p = a*b (full 2*WIDTH-bit product), signed or unsigned per operation,
// 3-stage pipeline with valid/ready handshake and a pass-through tag.
//   S1: registered Booth partial-product rows + negation correction bits
//   S2: registered carry-save sum/carry vectors
//   S3: registered final sum (p), out_tag, out_valid
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operation handshake (a, b, is_signed, in_tag)
//   out_valid / out_ready result handshake (p, out_tag)
module booth_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;   // product width
  localparam int EW = WIDTH + 2;   // extended operand width
  localparam int N  = WIDTH / 2 + 1; // Booth digit count

  // The whole pipe moves together; an empty S3 always lets it advance.
  logic advance;
  logic out_valid_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // ---------------- Booth recoding (feeds S1) ----------------
  logic [EW-1:0]  a_ext;
  logic [EW-1:0]  b_ext;
  logic [EW:0]    b_pad;
  logic [PW-1:0]  a_pw;
  logic [PW-1:0]  rows_d [N];
  logic [PW-1:0]  corr_d;

  assign a_ext = {{2{is_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{2{is_signed & b[WIDTH-1]}}, b};
  assign b_pad = {b_ext, 1'b0};                       // implicit b[-1] = 0
  assign a_pw  = {{(PW-EW){a_ext[EW-1]}}, a_ext};

  always_comb begin
    logic [2:0]    dig;
    logic [PW-1:0] mag;
    logic          neg;
    corr_d = '0;
    dig    = '0;
    mag    = '0;
    neg    = 1'b0;
    for (int i = 0; i < N; i++) begin
      dig = b_pad[2*i+2 -: 3];
      mag = '0;
      neg = 1'b0;
      case (dig)
        3'b001, 3'b010: mag = a_pw;
        3'b011:         mag = a_pw << 1;
        3'b100:         begin mag = a_pw << 1; neg = 1'b1; end
        3'b101, 3'b110: begin mag = a_pw;      neg = 1'b1; end
        default:        mag = '0;
      endcase
      // Invert before shifting so the vacated low bits stay zero; the +1 of
      // the two's-complement negation goes into the correction vector.
      rows_d[i]   = (neg ? ~mag : mag) << (2 * i);
      corr_d[2*i] = neg;
    end
  end

  // ---------------- S1 ----------------
  logic [PW-1:0]    s1_rows_q [N];
  logic [PW-1:0]    s1_corr_q;
  logic             s1_valid_q;
  logic [TAG_W-1:0] s1_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) s1_rows_q[i] <= '0;
      s1_corr_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
    end else if (advance) begin
      for (int i = 0; i < N; i++) s1_rows_q[i] <= rows_d[i];
      s1_corr_q  <= corr_d;
      s1_valid_q <= in_valid;
      s1_tag_q   <= in_tag;
    end
  end

  // ---------------- carry-save reduction (feeds S2) ----------------
  logic [PW-1:0] s2_sum_d;
  logic [PW-1:0] s2_carry_d;

  always_comb begin
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] r;
    s = s1_corr_q;
    c = '0;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r = s1_rows_q[i];
      // 3:2 compressor; carries weigh one bit higher, overflow past PW is dropped.
      {s, c} = {s ^ c ^ r, ((s & c) | (s & r) | (c & r)) << 1};
    end
    s2_sum_d   = s;
    s2_carry_d = c;
  end

  // ---------------- S2 ----------------
  logic [PW-1:0]    s2_sum_q;
  logic [PW-1:0]    s2_carry_q;
  logic             s2_valid_q;
  logic [TAG_W-1:0] s2_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sum_q   <= '0;
      s2_carry_q <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
    end else if (advance) begin
      s2_sum_q   <= s2_sum_d;
      s2_carry_q <= s2_carry_d;
      s2_valid_q <= s1_valid_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

  // ---------------- S3: final carry-propagate add ----------------
  logic [PW-1:0]    p_q;
  logic [TAG_W-1:0] out_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      p_q         <= s2_sum_q + s2_carry_q;
      out_tag_q   <= s2_tag_q;
      out_valid_q <= s2_valid_q;
    end
  end

  assign p         = p_q;
  assign out_tag   = out_tag_q;
  assign out_valid = out_valid_q;

endmodule
